benes_pipe_net: RTL and testbench

Parametrised, fully pipelined Benes permutation network with N = 2^LOG_N lanes of W bits and 2·LOG_N−1 registered switch stages. It adds a valid/ready data handshake with global stall, plus a double-banked switch configuration. Each beat carries the bank tag it was accepted with, so reconfiguration never corrupts beats already in flight. It is the generalised successor of the fixed 8-lane, 5-stage network and is the routing core between the input lane buffers and the output lane drivers.

---
 rtl/benes_pipe_net.sv | 156 +++++++++++++++
 tb/tb_benes_pipe_net.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_pipe_net.sv
`default_nettype none
// ==========================================================================
// benes_pipe_net : pipelined Benes permutation network with valid/ready flow
//                  control and tag-tracked double-banked switch configuration
// Revision       : 1.0
// ==========================================================================
module benes_pipe_net #(
    parameter int LOG_N = 3,
    parameter int W     = 4
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [(1<<LOG_N)*W-1:0]                              in_data,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [(1<<LOG_N)*W-1:0]                              out_data,
    input  logic                                                 cfg_we,
    input  logic [((2*LOG_N-1) > 1 ? $clog2(2*LOG_N-1) : 1)-1:0] cfg_stage,
    input  logic [(1<<LOG_N)/2-1:0]                              cfg_bits,
    input  logic                                                 cfg_commit,
    output logic                                                 cfg_ready,
    output logic                                                 active_bank
);

    localparam int N      = 1 << LOG_N;
    localparam int SW     = N / 2;
    localparam int STAGES = 2 * LOG_N - 1;
    localparam int SB     = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int CW     = $clog2(STAGES + 1);
    localparam logic [SB:0] STAGES_C = (SB + 1)'(STAGES);

    // Destination lane of position p after the inter-stage wiring of stage s.
    function automatic int wire_dst(input int s, input int p);
        int b;
        int j;
        if (s <= LOG_N - 2) begin
            b = N >> s;
            j = p % b;
            return p - j + (((j % 2) == 0) ? j / 2 : b / 2 + j / 2);
        end else if (s <= 2 * LOG_N - 3) begin
            b = N >> (2 * LOG_N - 3 - s);
            j = p % b;
            return p - j + ((j < b / 2) ? 2 * j : 2 * (j - b / 2) + 1);
        end
        return p;
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] tag_q, tag_d;
    logic [N*W-1:0]    data_q [STAGES];
    logic [N*W-1:0]    data_d [STAGES];
    logic [SW-1:0]     bank_q [2][STAGES];
    logic              active_q, active_d;
    logic [CW-1:0]     inflight_q [2];
    logic [CW-1:0]     inflight_d [2];

    logic w_advance;
    logic w_accept;
    logic w_out_hs;
    logic w_cfg_wr;

    assign w_advance   = !(valid_q[STAGES-1] && !out_ready);
    assign w_accept    = in_valid && w_advance;
    assign w_out_hs    = valid_q[STAGES-1] && out_ready;
    assign in_ready    = w_advance;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign active_bank = active_q;
    assign cfg_ready   = (inflight_q[~active_q] == '0);
    assign w_cfg_wr    = cfg_we && cfg_ready && ({1'b0, cfg_stage} < STAGES_C);
    assign active_d    = active_q ^ (cfg_commit && cfg_ready);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [N*W-1:0] w_in;
        logic [N*W-1:0] w_sw;
        logic [N*W-1:0] w_out;
        logic [SW-1:0]  w_bits;

        // Bubbles enter as zero data with tag 0 so idle slots stay clean.
        if (s == 0) begin : g_first
            assign w_in     = w_accept ? in_data : '0;
            assign w_bits   = bank_q[active_q][s];
            assign valid_d[s] = w_accept;
            assign tag_d[s]   = w_accept & active_q;
        end else begin : g_rest
            assign w_in     = data_q[s-1];
            assign w_bits   = bank_q[tag_q[s-1]][s];
            assign valid_d[s] = valid_q[s-1];
            assign tag_d[s]   = tag_q[s-1];
        end

        for (genvar k = 0; k < SW; k++) begin : g_sw
            assign w_sw[(2*k)*W +: W]   = w_bits[k] ? w_in[(2*k+1)*W +: W] : w_in[(2*k)*W +: W];
            assign w_sw[(2*k+1)*W +: W] = w_bits[k] ? w_in[(2*k)*W +: W]   : w_in[(2*k+1)*W +: W];
        end

        for (genvar p = 0; p < N; p++) begin : g_wire
            localparam int DST = wire_dst(s, p);
            assign w_out[DST*W +: W] = w_sw[p*W +: W];
        end

        assign data_d[s] = w_out;
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            inflight_d[b] = inflight_q[b];
            if (w_accept && (active_q == 1'(b))) begin
                inflight_d[b] = inflight_d[b] + CW'(1);
            end
            if (w_out_hs && (tag_q[STAGES-1] == 1'(b))) begin
                inflight_d[b] = inflight_d[b] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else if (w_advance) begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= data_d[s];
            end
        end
    end

    // The write uses the pre-commit shadow index, so a same-cycle commit
    // activates the bank that has just been written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                inflight_q[b] <= '0;
                for (int s = 0; s < STAGES; s++) begin
                    bank_q[b][s] <= '0;
                end
            end
        end else begin
            active_q   <= active_d;
            inflight_q <= inflight_d;
            if (w_cfg_wr) begin
                bank_q[~active_q][cfg_stage] <= cfg_bits;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_benes_pipe_net.sv
`default_nettype none
// ==========================================================================
// tb_benes_pipe_net : directed self-checking bench for benes_pipe_net (N=8, W=4)
// Revision          : 1.0
// ==========================================================================
module tb_benes_pipe_net;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_stage = '0;
    logic [3:0]  cfg_bits = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_ready;
    logic        active_bank;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-derived lane sources: out lane q takes in lane P[q].
    int P_ID    [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int P_CROSS [8] = '{4, 1, 2, 3, 0, 5, 6, 7};
    int P_SWAP0 [8] = '{1, 0, 2, 3, 4, 5, 6, 7};

    benes_pipe_net #(.LOG_N(3), .W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_bits(cfg_bits),
        .cfg_commit(cfg_commit), .cfg_ready(cfg_ready), .active_bank(active_bank)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int base);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(base + i);
        return r;
    endfunction

    function automatic logic [31:0] permute(input logic [31:0] d, input int p [8]);
        logic [31:0] r;
        for (int q = 0; q < 8; q++) r[q*4 +: 4] = d[p[q]*4 +: 4];
        return r;
    endfunction

    // Reference Benes network built directly from the switch/wiring rules.
    function automatic logic [31:0] benes_ref(input logic [31:0] d, input logic [3:0] c [5]);
        logic [3:0] v [8];
        logic [3:0] t [8];
        logic [3:0] x;
        logic [31:0] r;
        int b, j, dst;
        for (int i = 0; i < 8; i++) v[i] = d[i*4 +: 4];
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (c[s][k]) begin
                    x = v[2*k]; v[2*k] = v[2*k+1]; v[2*k+1] = x;
                end
            end
            if (s < 4) begin
                b = (s <= 1) ? (8 >> s) : (8 >> (3 - s));
                for (int p = 0; p < 8; p++) begin
                    j = p % b;
                    if (s <= 1) dst = p - j + (((j % 2) == 0) ? j / 2 : b / 2 + j / 2);
                    else        dst = p - j + ((j < b / 2) ? 2 * j : 2 * (j - b / 2) + 1);
                    t[dst] = v[p];
                end
                v = t;
            end
        end
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = v[i];
        return r;
    endfunction

    // Called at a negedge with the pipe idle; returns latency in cycles.
    task automatic send_one(input logic [31:0] d, output int lat, output logic [31:0] got);
        lat = -1;
        got = '0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                lat = k + 1;
                got = out_data;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic cfg_op(input logic [2:0] st, input logic [3:0] bits, input logic we, input logic cm);
        int k;
        k = 0;
        while (!cfg_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cfg_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cfg_ready_timeout: cfg_ready=%0b required 1", cfg_ready);
        end
        cfg_stage = st; cfg_bits = bits; cfg_we = we; cfg_commit = cm;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL reset_active_bank: got %b expected 0", active_bank); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity;
        int lat;
        logic [31:0] got;
        send_one(mk(0), lat, got);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL identity_latency: got %0d expected 5", lat); end
        n_checks++; if (got !== 32'h7654_3210) begin n_fail++; $display("FAIL identity_data: got %h expected 76543210", got); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL identity_single_beat: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_single_cross;
        int lat;
        logic [31:0] got;
        cfg_op(3'd2, 4'b0001, 1'b1, 1'b1);
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL cross_active_bank: got %b expected 1", active_bank); end
        send_one(mk(0), lat, got);
        n_checks++; if (lat != 5) begin n_fail++; $display("FAIL cross_latency: got %0d expected 5", lat); end
        n_checks++; if (got !== 32'h7650_3214) begin n_fail++; $display("FAIL cross_data: got %h expected 76503214", got); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] got [$];
        logic [31:0] exp;
        int sent, low;
        cfg_op(3'd0, 4'b0001, 1'b1, 1'b0);
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL b2b_write_no_flip: got %b expected 1", active_bank); end
        sent = 0;
        low  = 0;
        for (int c = 0; c < 30; c++) begin
            if (!cfg_ready) low++;
            if (out_valid) got.push_back(out_data);
            in_valid   = (sent < 10);
            in_data    = mk(16 + sent);
            cfg_commit = (sent == 4);
            if (sent < 10) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; cfg_commit = 1'b0;
        n_checks++; if (got.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            exp = (i < 5) ? permute(mk(16 + i), P_CROSS) : permute(mk(16 + i), P_SWAP0);
            n_checks++; if (got[i] !== exp) begin n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", i, got[i], exp); end
        end
        n_checks++; if (low != 5) begin n_fail++; $display("FAIL b2b_cfg_ready_low: got %0d cycles expected 5", low); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL b2b_active_bank: got %b expected 0", active_bank); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rcv [$];
        logic [31:0] hold;
        logic [31:0] exp;
        int sent, stall;
        sent  = 0;
        stall = 0;
        hold  = '0;
        for (int c = 0; c < 60 && rcv.size() < 8; c++) begin
            out_ready = (stall >= 7);
            in_valid  = (sent < 8);
            in_data   = mk(40 + sent);
            #1;
            if (out_valid && !out_ready) begin
                if (stall == 0) begin
                    hold = out_data;
                    exp  = permute(mk(40), P_SWAP0);
                    n_checks++; if (hold !== exp) begin n_fail++; $display("FAIL bp_first_out: got %h expected %h", hold, exp); end
                end
                stall++;
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                n_checks++; if (out_data !== hold) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", out_data, hold); end
            end
            if (out_valid && out_ready) rcv.push_back(out_data);
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (stall != 7) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 7", stall); end
        n_checks++; if (rcv.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", rcv.size()); end
        for (int i = 0; i < rcv.size() && i < 8; i++) begin
            exp = permute(mk(40 + i), P_SWAP0);
            n_checks++; if (rcv[i] !== exp) begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", i, rcv[i], exp); end
        end
    endtask

    task automatic test_illegal;
        int lat, k;
        logic [31:0] got;
        cfg_op(3'd6, 4'b1111, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = mk(50); cfg_commit = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; cfg_commit = 1'b0;
        n_checks++; if (active_bank !== 1'b1) begin n_fail++; $display("FAIL ill_commit: got %b expected 1", active_bank); end
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL ill_cfg_ready_busy: got %b expected 0", cfg_ready); end
        cfg_we = 1'b1; cfg_stage = 3'd0; cfg_bits = 4'b1111;
        @(negedge clk);
        cfg_we = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        got = out_data;
        n_checks++; if (got !== permute(mk(50), P_SWAP0) || !out_valid) begin
            n_fail++; $display("FAIL ill_old_tag_beat: got %h expected %h", got, permute(mk(50), P_SWAP0));
        end
        @(negedge clk);
        send_one(mk(60), lat, got);
        n_checks++; if (got !== permute(mk(60), P_CROSS)) begin n_fail++; $display("FAIL ill_bank1_intact: got %h expected %h", got, permute(mk(60), P_CROSS)); end
        cfg_op(3'd0, 4'b0000, 1'b0, 1'b1);
        send_one(mk(70), lat, got);
        n_checks++; if (got !== permute(mk(70), P_SWAP0)) begin n_fail++; $display("FAIL ill_bank0_intact: got %h expected %h", got, permute(mk(70), P_SWAP0)); end
    endtask

    task automatic test_random_reset;
        logic [3:0]  rc [5];
        logic [31:0] sq [$];
        logic [31:0] rq [$];
        logic [31:0] exp;
        logic [31:0] got;
        int sent, lat, bad;
        for (int s = 0; s < 5; s++) begin
            rc[s] = 4'($urandom_range(0, 15));
            cfg_op(3'(s), rc[s], 1'b1, (s == 4));
        end
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) rq.push_back(out_data);
            in_valid = (sent < 6);
            in_data  = $urandom;
            if (sent < 6) begin
                sq.push_back(in_data);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++; if (rq.size() != 6) begin n_fail++; $display("FAIL rnd_count: got %0d expected 6", rq.size()); end
        for (int i = 0; i < rq.size() && i < 6; i++) begin
            exp = benes_ref(sq[i], rc);
            n_checks++; if (rq[i] !== exp) begin n_fail++; $display("FAIL rnd_beat%0d: got %h expected %h", i, rq[i], exp); end
        end
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_out_data: got %h expected 0", out_data); end
        n_checks++; if (active_bank !== 1'b0) begin n_fail++; $display("FAIL rst_mid_active: got %b expected 0", active_bank); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cfg_ready: got %b expected 1", cfg_ready); end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_no_partial: got %0d valid cycles expected 0", bad); end
        send_one(mk(80), lat, got);
        n_checks++; if (got !== permute(mk(80), P_ID)) begin n_fail++; $display("FAIL rst_banks_cleared: got %h expected %h", got, permute(mk(80), P_ID)); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_single_cross();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_random_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
